pe_conf_tx: RTL and testbench

Array-side transmitter for the PE configuration/instruction interface. It accepts one packed PE configuration (PECfg::Conf, 73 bits) from the tile controller and serializes it LSB-first onto the narrow PCONFDWD-bit PE config port with a valid/ready handshake. It then sequences the PE through reset and start, drives the Inst word during the run, and closes the run on the PE's DFStatus.confEnd. There is one instance per PE column.

---
 rtl/pe_conf_tx_if.sv | 36 +++
 rtl/pe_conf_tx.sv | 194 +++++++++++++++++++
 tb/tb_pe_conf_tx.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/pe_conf_tx_if.sv
// Bundles the tile-controller and PE-facing signals of pe_conf_tx.
// slave: the transmitter's view. master: the environment's view.
interface pe_conf_tx_if #(
  parameter int unsigned PCONFDWD = 6,
  parameter int unsigned CONFW    = 73
) ();

  // Tile controller side
  logic [CONFW-1:0]    conf_i;
  logic                conf_valid_i;
  logic                conf_ready_o;

  // PE config port
  logic [PCONFDWD-1:0] pconf_data_o;
  logic                pconf_valid_o;
  logic                pconf_ready_i;

  // Run control
  logic                dval_i;
  logic                stall_i;
  logic [3:0]          inst_o;    // {start, stall, reset, dval}
  logic [1:0]          status_i;  // {lastPix, confEnd}
  logic                busy_o;
  logic                done_o;

  modport slave (
    input  conf_i, conf_valid_i, pconf_ready_i, dval_i, stall_i, status_i,
    output conf_ready_o, pconf_data_o, pconf_valid_o, inst_o, busy_o, done_o
  );

  modport master (
    output conf_i, conf_valid_i, pconf_ready_i, dval_i, stall_i, status_i,
    input  conf_ready_o, pconf_data_o, pconf_valid_o, inst_o, busy_o, done_o
  );

endinterface

// File: rtl/pe_conf_tx.sv
// PE configuration transmitter: serializes one packed PE configuration
// LSB-first onto the narrow PE config port, then sequences the PE through
// reset, start and run, ending the run on DFStatus.confEnd.
// Optional macro PECONF_PARITY_EN appends one column-parity beat (XOR of all
// data beats) after the data beats.
// All outputs are registered; next values are computed in the FSM process.
module pe_conf_tx #(
  parameter int unsigned PCONFDWD = 6,
  parameter int unsigned CONFW    = 73
) (
  input logic          clk,
  input logic          rst,
  pe_conf_tx_if.slave  bus
);

  localparam int unsigned NBEAT = (CONFW + PCONFDWD - 1) / PCONFDWD;
  localparam int unsigned PADW  = NBEAT * PCONFDWD;
`ifdef PECONF_PARITY_EN
  localparam int unsigned NXFER = NBEAT + 1;
`else
  localparam int unsigned NXFER = NBEAT;
`endif
  localparam int unsigned CNTW  = (NXFER > 1) ? $clog2(NXFER) : 1;

  // Inst / DFStatus bit positions
  localparam int unsigned INST_DVAL   = 0;
  localparam int unsigned INST_RESET  = 1;
  localparam int unsigned INST_STALL  = 2;
  localparam int unsigned INST_START  = 3;
  localparam int unsigned ST_CONF_END = 0;

  localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(NXFER - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND   = 3'd1,
    PRST   = 3'd2,
    PSTART = 3'd3,
    RUN    = 3'd4
  } state_t;

  state_t              state, state_d;
  logic [CNTW-1:0]     cnt, cnt_d;
  logic [CONFW-1:0]    shadow, shadow_d;
  logic                pconf_valid, pconf_valid_d;
  logic [PCONFDWD-1:0] pconf_data, pconf_data_d;
  logic [3:0]          inst, inst_d;
  logic                done, done_d;
  logic                busy, busy_d;
  logic                conf_ready, conf_ready_d;

  // lastPix is reserved and intentionally not consumed
  logic unused_last_pix;
  assign unused_last_pix = bus.status_i[1];

  // Data beat idx of a zero-padded configuration
  function automatic logic [PCONFDWD-1:0] data_beat(input logic [PADW-1:0] pad,
                                                    input logic [CNTW-1:0] idx);
    logic [PADW-1:0] sh;
    sh = pad >> (32'(idx) * PCONFDWD);
    return sh[PCONFDWD-1:0];
  endfunction

`ifdef PECONF_PARITY_EN
  // Column parity: XOR of all data beats
  function automatic logic [PCONFDWD-1:0] parity_beat(input logic [PADW-1:0] pad);
    logic [PADW-1:0]     sh;
    logic [PCONFDWD-1:0] p;
    p = '0;
    for (int unsigned b = 0; b < NBEAT; b++) begin
      sh = pad >> (b * PCONFDWD);
      p  = p ^ sh[PCONFDWD-1:0];
    end
    return p;
  endfunction
`endif

  // Any transfer beat, including the parity beat when enabled
  function automatic logic [PCONFDWD-1:0] xfer_beat(input logic [PADW-1:0] pad,
                                                    input logic [CNTW-1:0] idx);
`ifdef PECONF_PARITY_EN
    if (idx == CNTW'(NBEAT)) begin
      return parity_beat(pad);
    end
`endif
    return data_beat(pad, idx);
  endfunction

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      shadow      <= '0;
      pconf_valid <= 1'b0;
      pconf_data  <= '0;
      inst        <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
      conf_ready  <= 1'b1;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      shadow      <= shadow_d;
      pconf_valid <= pconf_valid_d;
      pconf_data  <= pconf_data_d;
      inst        <= inst_d;
      done        <= done_d;
      busy        <= busy_d;
      conf_ready  <= conf_ready_d;
    end
  end

  // Next state, counter, shadow and next output values
  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    shadow_d      = shadow;
    pconf_valid_d = pconf_valid;
    pconf_data_d  = pconf_data;
    inst_d        = '0;
    done_d        = 1'b0;
    conf_ready_d  = 1'b0;

    case (state)
      IDLE: begin
        conf_ready_d  = 1'b1;
        pconf_valid_d = 1'b0;
        pconf_data_d  = '0;
        if (bus.conf_valid_i && conf_ready) begin
          state_d       = SEND;
          cnt_d         = '0;
          shadow_d      = bus.conf_i;
          pconf_valid_d = 1'b1;
          pconf_data_d  = xfer_beat(PADW'(bus.conf_i), '0);
          conf_ready_d  = 1'b0;
        end
      end

      SEND: begin
        // Data and valid hold until the PE takes the beat
        if (pconf_valid && bus.pconf_ready_i) begin
          if (cnt == LAST_BEAT) begin
            state_d            = PRST;
            pconf_valid_d      = 1'b0;
            pconf_data_d       = '0;
            inst_d[INST_RESET] = 1'b1;
          end else begin
            cnt_d        = cnt + CNTW'(1);
            pconf_data_d = xfer_beat(PADW'(shadow), cnt + CNTW'(1));
          end
        end
      end

      PRST: begin
        state_d            = PSTART;
        inst_d[INST_START] = 1'b1;
      end

      PSTART: begin
        state_d = RUN;
      end

      RUN: begin
        // confEnd takes priority over a concurrent stall
        if (bus.status_i[ST_CONF_END]) begin
          state_d      = IDLE;
          done_d       = 1'b1;
          conf_ready_d = 1'b1;
        end else begin
          inst_d[INST_STALL] = bus.stall_i;
          inst_d[INST_DVAL]  = bus.dval_i & ~bus.stall_i;
        end
      end

      default: begin
        state_d       = IDLE;
        pconf_valid_d = 1'b0;
        pconf_data_d  = '0;
        conf_ready_d  = 1'b1;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.conf_ready_o  = conf_ready;
  assign bus.pconf_valid_o = pconf_valid;
  assign bus.pconf_data_o  = pconf_data;
  assign bus.inst_o        = inst;
  assign bus.busy_o        = busy;
  assign bus.done_o        = done;

endmodule

// File: tb/tb_pe_conf_tx.sv
// Directed testbench for pe_conf_tx: table of configurations with
// hand-computed beats, plus sequences for backpressure, ignored events,
// back-to-back runs and reset mid-transfer.
module tb_pe_conf_tx;

  localparam int unsigned PCONFDWD = 6;
  localparam int unsigned CONFW    = 73;
  localparam int unsigned NBEAT    = 13;
`ifdef PECONF_PARITY_EN
  localparam int unsigned NX = NBEAT + 1;
`else
  localparam int unsigned NX = NBEAT;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pe_conf_tx_if #(.PCONFDWD(PCONFDWD), .CONFW(CONFW)) bus ();

  pe_conf_tx #(.PCONFDWD(PCONFDWD), .CONFW(CONFW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [CONFW-1:0] conf;
    logic [5:0]       b0;
    logic [5:0]       b1;
    logic [5:0]       brest;  // beats 2..11
    logic [5:0]       b12;
    logic [5:0]       par;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full output snapshot check
  task automatic chk_io(input string tag, input logic ev, input logic [5:0] ed,
                        input logic [3:0] ei, input logic edn, input logic eb,
                        input logic er);
    chk({tag, "_valid"}, 16'(bus.pconf_valid_o), 16'(ev));
    chk({tag, "_data"},  16'(bus.pconf_data_o),  16'(ed));
    chk({tag, "_inst"},  16'(bus.inst_o),        16'(ei));
    chk({tag, "_done"},  16'(bus.done_o),        16'(edn));
    chk({tag, "_busy"},  16'(bus.busy_o),        16'(eb));
    chk({tag, "_ready"}, 16'(bus.conf_ready_o),  16'(er));
  endtask

  function automatic logic [5:0] vec_beat(input vec_t v, input int k);
    if (k == 0)       return v.b0;
    else if (k == 1)  return v.b1;
    else if (k < 12)  return v.brest;
    else if (k == 12) return v.b12;
    else              return v.par;
  endfunction

  // Ramp configuration: data beat k carries k+1, beat 12 carries 1
  function automatic logic [5:0] ramp_beat(input int k);
    if (k < 12)       return 6'(k + 1);
    else if (k == 12) return 6'h01;
    else              return 6'h0D;  // 1^2^..^12 = 12, ^1 = 13
  endfunction

  // Full transfer plus run sequence for one table entry
  task automatic run_vec(input vec_t v, input int idx);
    logic [NBEAT*PCONFDWD-1:0] rx;
    string tag;
    rx  = '0;
    tag = $sformatf("v%0d", idx);
    bus.conf_i       = v.conf;
    bus.conf_valid_i = 1'b1;
    bus.pconf_ready_i = 1'b1;
    chk({tag, "_idle_ready"}, 16'(bus.conf_ready_o), 16'(1));
    step();
    bus.conf_valid_i = 1'b0;
    for (int k = 0; k < NX; k++) begin
      chk($sformatf("%s_beat%0d_valid", tag, k), 16'(bus.pconf_valid_o), 16'(1));
      chk($sformatf("%s_beat%0d_data", tag, k),  16'(bus.pconf_data_o),  16'(vec_beat(v, k)));
      chk($sformatf("%s_beat%0d_busy", tag, k),  16'(bus.busy_o),        16'(1));
      if (k < NBEAT) rx = rx | ((NBEAT*PCONFDWD)'(bus.pconf_data_o) << (k * PCONFDWD));
      step();
    end
    chk({tag, "_roundtrip"}, 16'(rx[CONFW-1:0] == v.conf), 16'(1));
    chk({tag, "_padding"},   16'(rx[NBEAT*PCONFDWD-1:CONFW]), 16'(0));
    chk_io({tag, "_prst"}, 1'b0, 6'h00, 4'b0010, 1'b0, 1'b1, 1'b0);
    step();
    chk_io({tag, "_pstart"}, 1'b0, 6'h00, 4'b1000, 1'b0, 1'b1, 1'b0);
    step();
    chk_io({tag, "_run0"}, 1'b0, 6'h00, 4'b0000, 1'b0, 1'b1, 1'b0);
    bus.dval_i = 1'b1; bus.stall_i = 1'b0;
    step();
    chk({tag, "_run_dval"}, 16'(bus.inst_o), 16'(4'b0001));
    bus.stall_i = 1'b1;
    step();
    chk({tag, "_run_stall"}, 16'(bus.inst_o), 16'(4'b0100));
    bus.stall_i = 1'b0;
    step();
    chk({tag, "_run_unstall"}, 16'(bus.inst_o), 16'(4'b0001));
    bus.status_i = 2'b01; bus.stall_i = 1'b1;
    step();
    chk_io({tag, "_done"}, 1'b0, 6'h00, 4'b0000, 1'b1, 1'b0, 1'b1);
    bus.status_i = 2'b00; bus.stall_i = 1'b0; bus.dval_i = 1'b0;
    step();
    chk({tag, "_done_pulse"}, 16'(bus.done_o), 16'(0));
  endtask

  initial begin
    logic [CONFW-1:0] ramp;

    vecs[0] = '{conf: 73'h3F,                     b0: 6'h3F, b1: 6'h00, brest: 6'h00, b12: 6'h00, par: 6'h3F};
    vecs[1] = '{conf: 73'h1_0000_0000_0000_0000_00, b0: 6'h00, b1: 6'h00, brest: 6'h00, b12: 6'h01, par: 6'h01};
    vecs[2] = '{conf: '1,                         b0: 6'h3F, b1: 6'h3F, brest: 6'h3F, b12: 6'h01, par: 6'h01};
    vecs[3] = '{conf: 73'h1_5555_5555_5555_5555_55, b0: 6'h15, b1: 6'h15, brest: 6'h15, b12: 6'h01, par: 6'h01};
    vecs[4] = '{conf: 73'hFC0,                    b0: 6'h00, b1: 6'h3F, brest: 6'h00, b12: 6'h00, par: 6'h3F};

    ramp = '0;
    for (int k = 0; k < 12; k++) ramp = ramp | (CONFW'(k + 1) << (6 * k));
    ramp = ramp | (CONFW'(1) << 72);

    rst = 1'b1;
    bus.conf_i = '0; bus.conf_valid_i = 1'b0; bus.pconf_ready_i = 1'b0;
    bus.dval_i = 1'b0; bus.stall_i = 1'b0; bus.status_i = 2'b00;
    step();
    step();
    rst = 1'b0;
    chk_io("reset", 1'b0, 6'h00, 4'b0000, 1'b0, 1'b0, 1'b1);
    step();
    chk_io("idle", 1'b0, 6'h00, 4'b0000, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Backpressure on beat 4, with relatch attempts and confEnd while busy
    bus.conf_i = ramp; bus.conf_valid_i = 1'b1; bus.pconf_ready_i = 1'b1;
    step();
    bus.conf_i = '1;
    bus.status_i = 2'b01;
    for (int k = 0; k < NX; k++) begin
      if (k == 4) begin
        bus.pconf_ready_i = 1'b0;
        for (int h = 0; h < 5; h++) begin
          chk($sformatf("bp_hold%0d_valid", h), 16'(bus.pconf_valid_o), 16'(1));
          chk($sformatf("bp_hold%0d_data", h),  16'(bus.pconf_data_o),  16'(6'h05));
          step();
        end
        bus.pconf_ready_i = 1'b1;
      end
      chk($sformatf("bp_beat%0d_valid", k), 16'(bus.pconf_valid_o), 16'(1));
      chk($sformatf("bp_beat%0d_data", k),  16'(bus.pconf_data_o),  16'(ramp_beat(k)));
      chk($sformatf("bp_beat%0d_ready", k), 16'(bus.conf_ready_o),  16'(0));
      step();
    end
    chk_io("bp_prst", 1'b0, 6'h00, 4'b0010, 1'b0, 1'b1, 1'b0);
    step();
    chk_io("bp_pstart", 1'b0, 6'h00, 4'b1000, 1'b0, 1'b1, 1'b0);
    step();
    chk_io("bp_run0", 1'b0, 6'h00, 4'b0000, 1'b0, 1'b1, 1'b0);
    bus.status_i = 2'b00; bus.conf_valid_i = 1'b0;
    bus.dval_i = 1'b1; bus.stall_i = 1'b1;
    step();
    chk("bp_run_stall", 16'(bus.inst_o), 16'(4'b0100));
    bus.status_i = 2'b01; bus.stall_i = 1'b0;
    step();
    chk_io("b2b_done", 1'b0, 6'h00, 4'b0000, 1'b1, 1'b0, 1'b1);

    // Back-to-back: accept a new configuration in the done cycle
    bus.status_i = 2'b00; bus.dval_i = 1'b0;
    bus.conf_i = 73'h3F; bus.conf_valid_i = 1'b1;
    step();
    bus.conf_valid_i = 1'b0;
    chk_io("b2b_beat0", 1'b1, 6'h3F, 4'b0000, 1'b0, 1'b1, 1'b0);

    // Reset while beat 7 is on the port
    for (int k = 0; k < 7; k++) step();
    chk("mid_beat7_valid", 16'(bus.pconf_valid_o), 16'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_io("midrst", 1'b0, 6'h00, 4'b0000, 1'b0, 1'b0, 1'b1);
    bus.conf_i = ramp; bus.conf_valid_i = 1'b1;
    step();
    bus.conf_valid_i = 1'b0;
    chk_io("restart_beat0", 1'b1, 6'h01, 4'b0000, 1'b0, 1'b1, 1'b0);
    step();
    chk("restart_beat1_data", 16'(bus.pconf_data_o), 16'(6'h02));
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
